pc_sequencer: RTL
=================

# pc_sequencer

Next-PC control unit that drives the `pc` block's `jump_en`/`target` inputs each cycle. It decodes a per-instruction branch type from the decoder, resolves targets through a small software-loaded target lookup table (LUT), and maintains a return-address stack for call/return. It also implements start, stall, halt and error by steering the PC. Because `pc` has no hold input, the sequencer freezes the PC by issuing a self-jump (`target = prog_ctr`).

## Interface
Parameters:
- D, 6, PC width; must match `pc`.
- LUT_N, 8, number of target LUT entries; index width is log2(LUT_N) = 3.
- RS_DEPTH, 4, return-stack depth.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  IDLE→RUN request.
- stall  in  1  freeze PC this cycle (RUN only).
- br_type  in  3  0 none, 1 jump, 2 branch-if-zero, 3 call, 4 ret, 5 halt, 6/7 treated as none.
- br_idx  in  3  LUT index for jump/bz/call.
- zero  in  1  ALU zero flag for branch-if-zero.
- prog_ctr  in  D  current PC from `pc`.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  3  LUT write address.
- lut_wdata  in  D  LUT write data.
- jump_en  out  1  to `pc`; combinational.
- target  out  D  to `pc`; combinational.
- done  out  1  registered; high in HALT.
- err  out  1  registered; high in ERR.
- rs_count  out  3  registered; current return-stack occupancy, 0..RS_DEPTH.

## Operation
- States: IDLE, RUN, HALT, ERR.
  - Reset enters IDLE.
  - IDLE→RUN on `start`.
  - RUN→HALT on br_type 5.
  - RUN→ERR on call with a full stack or ret with an empty stack.
  - HALT and ERR are left only by reset.
- Hold mechanism: hold means `jump_en=1, target=prog_ctr`.
- Outputs per state:
  - IDLE: hold, including the cycle `start` is sampled.
  - HALT, ERR: hold.
  - RUN with `stall=1`: hold. Stall has priority over every br_type, and the stack and state are unchanged.
- RUN, `stall=0`, by br_type:
  - none: `jump_en=0`, `target=0`; PC increments.
  - jump: `jump_en=1`, `target=lut[br_idx]`.
  - bz, `zero=1`: same as jump.
  - bz, `zero=0`: same as none.
  - call, stack not full: push `(prog_ctr+1) mod 2^D` and jump to `lut[br_idx]`.
  - ret, stack not empty: pop and jump to the popped address.
  - halt: hold; state becomes HALT.
  - call when full, or ret when empty: hold; no push or pop; state becomes ERR.
- Return stack: LIFO with a pointer; the wrap of `prog_ctr+1` at 2^D−1 gives 0.
- LUT:
  - Writable in every state, including during stall/HALT/ERR.
  - A write and a read of the same index in the same cycle returns the old value; the new value is visible next cycle.
- During reset (`reset=1`): `jump_en=0`, `target=0`; the `pc` block resets itself.

## Timing
- Redirect latency: 1 cycle. `target` is loaded into `pc` at the same edge that retires the current instruction, with no bubble.
- Register reset values: state=IDLE, stack pointer=0, `rs_count=0`, `done=0`, `err=0`, all LUT entries=0.
- `done`/`err` rise on the edge that enters HALT/ERR, i.e. one cycle after the halt or faulting instruction is presented.
- Push, pop and `rs_count` update on the edge of the call/ret cycle.
- Reset asserted mid-operation returns the block to IDLE on the next edge, clearing the stack, flags and LUT.

## Test plan
- Reset, then `start` pulse, br_type=0 → PC holds at 0 through IDLE, then counts 0,1,2,3 in RUN; `done=err=0`.
- Load `lut[2]=40`; at PC 5 issue jump idx 2 → next PC 40. Repeat with bz idx 2: `zero=0` → PC 6, `zero=1` → PC 40.
- Load `lut[1]=20`; call idx 1 at PC 10 → PC 20, `rs_count=1`; ret at PC 22 → PC 11, `rs_count=0`; call at PC 63 pushes 0.
- Five nested calls → fifth call holds the PC and sets `err=1`, with `rs_count` staying at 4; separately, ret on an empty stack → `err=1`, PC frozen.
- `stall=1` for 3 cycles with br_type=jump asserted → PC constant, no redirect; the jump is taken on the first cycle after `stall` drops.
- Halt at PC 7 → PC stays 7 and `done=1` next cycle; `start` is ignored; reset returns to IDLE with PC 0 and `done=0`.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC steering for the pc block, with a target LUT, a return stack
// and run/halt/error control; the PC is frozen by jumping it to itself.
module pc_sequencer #(
    parameter int D        = 6,
    parameter int LUT_N    = 8,
    parameter int RS_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stall,
    input  logic [2:0]                    br_type,
    input  logic [$clog2(LUT_N)-1:0]      br_idx,
    input  logic                          zero,
    input  logic [D-1:0]                  prog_ctr,
    input  logic                          lut_we,
    input  logic [$clog2(LUT_N)-1:0]      lut_waddr,
    input  logic [D-1:0]                  lut_wdata,
    output logic                          jump_en,
    output logic [D-1:0]                  target,
    output logic                          done,
    output logic                          err,
    output logic [$clog2(RS_DEPTH+1)-1:0] rs_count
);
    localparam int CW = $clog2(RS_DEPTH + 1);
    localparam int SW = $clog2(RS_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2, S_ERR = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] sp_q, sp_d, sp_m1;
    logic [D-1:0]  lut_q [LUT_N];
    logic [D-1:0]  stk_q [RS_DEPTH];
    logic          done_q, err_q;
    logic          go, take, push, pop, fault, hold;
    always_comb begin
        go      = state_q == S_RUN && !stall;
        sp_m1   = sp_q - CW'(1);
        push    = go && br_type == 3'd3 && sp_q != CW'(RS_DEPTH);
        pop     = go && br_type == 3'd4 && sp_q != '0;
        fault   = go && ((br_type == 3'd3 && !push) || (br_type == 3'd4 && !pop));
        take    = (go && (br_type == 3'd1 || (br_type == 3'd2 && zero))) || push || pop;
        hold    = !go || br_type == 3'd5 || fault;
        jump_en = !reset && (hold || take);
        target  = reset ? '0 : hold ? prog_ctr : pop ? stk_q[sp_m1[SW-1:0]] : take ? lut_q[br_idx] : '0;
        sp_d    = push ? sp_q + CW'(1) : pop ? sp_m1 : sp_q;
        state_d = (state_q == S_IDLE && start) ? S_RUN :
                  (go && br_type == 3'd5) ? S_HALT : fault ? S_ERR : state_q;
    end
    // LUT reads come from the registered array, so a same-cycle write shows up only next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            done_q  <= state_d == S_HALT;
            err_q   <= state_d == S_ERR;
            if (lut_we) lut_q[lut_waddr] <= lut_wdata;
            if (push) stk_q[sp_q[SW-1:0]] <= prog_ctr + D'(1);
        end
    end
    assign done     = done_q;
    assign err      = err_q;
    assign rs_count = sp_q;
endmodule
